// File: rtl/wb_master_engine_if.sv
// Wishbone bus bundle between one master engine and one slave.
// Latency: none, wires only.
// Backpressure: the slave stalls the master by withholding ACK_I/ERR_I/RTY_I.
interface wb_master_engine_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic [AW-1:0]   ADR_O;
    logic [DW-1:0]   DAT_O;
    logic [DW-1:0]   DAT_I;
    logic [DW/8-1:0] SEL_O;
    logic            CYC_O;
    logic            STB_O;
    logic            WE_O;
    logic            ACK_I;
    logic            ERR_I;
    logic            RTY_I;

    modport master (
        output ADR_O, DAT_O, SEL_O, CYC_O, STB_O, WE_O,
        input  DAT_I, ACK_I, ERR_I, RTY_I
    );

    modport slave (
        input  ADR_O, DAT_O, SEL_O, CYC_O, STB_O, WE_O,
        output DAT_I, ACK_I, ERR_I, RTY_I
    );
endinterface

// File: rtl/wb_master_engine.sv
// Wishbone master: runs one single/burst read or write command, with retry, error and optional timeout (WBM_TIMEOUT_EN).
// Latency: strobe 1 cycle after accept; done pulses 2 cycles after the terminating ACK/ERR/RTY/timeout edge.
// Backpressure: cmd_ready only while idle; slave wait states hold STB_O; write data pulled via wdat_next.
module wb_master_engine #(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int LENW      = 3,
    parameter int RETRY_MAX = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic            CLK_I,
    input  logic            RST_I,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [LENW-1:0] cmd_len,
    input  logic [DW/8-1:0] cmd_sel,
    input  logic [DW-1:0]   wdat_i,
    output logic            wdat_next,
    output logic [DW-1:0]   rdat_o,
    output logic            rdat_valid,
    output logic            done,
    output logic [1:0]      status,
    wb_master_engine_if.master wb
);
    localparam int SW = DW / 8;
    localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_ERR  = 2'b01;
    localparam logic [1:0] ST_RTY  = 2'b10;
    localparam logic [1:0] ST_TOUT = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_BACKOFF, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic            we_q, we_d;
    logic            cyc_q, cyc_d;
    logic            stb_q, stb_d;
    logic [LENW-1:0] beats_q, beats_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [1:0]      pend_q, pend_d;
    logic [1:0]      status_q, status_d;
    logic            done_q, done_d;
    logic [DW-1:0]   rdat_q, rdat_d;
    logic            rvld_q, rvld_d;

`ifdef WBM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]   to_q, to_d;
`endif

    logic accept;
    logic hit_err, hit_rty, hit_ack;

    // A new command may not land in the same cycle the previous done is still visible.
    assign cmd_ready = (state_q == S_IDLE) && !done_q;
    assign accept    = cmd_valid && cmd_ready;

    // Slave responses only count against a live strobe; ERR beats RTY beats ACK.
    assign hit_err = stb_q && wb.ERR_I;
    assign hit_rty = stb_q && !wb.ERR_I && wb.RTY_I;
    assign hit_ack = stb_q && !wb.ERR_I && !wb.RTY_I && wb.ACK_I;

    // Next-state and next bus values; every register holds unless a transition says otherwise.
    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        beats_d   = beats_q;
        retry_d   = retry_q;
        pend_d    = pend_q;
        status_d  = status_q;
        done_d    = 1'b0;
        rdat_d    = rdat_q;
        rvld_d    = 1'b0;
        wdat_next = 1'b0;
`ifdef WBM_TIMEOUT_EN
        to_d      = to_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_BUS;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    adr_d   = cmd_adr;
                    we_d    = cmd_we;
                    sel_d   = cmd_we ? cmd_sel : '1;
                    beats_d = cmd_len;
                    retry_d = '0;
`ifdef WBM_TIMEOUT_EN
                    to_d    = '0;
`endif
                    if (cmd_we) begin
                        dat_d     = wdat_i;
                        wdat_next = 1'b1;
                    end
                end
            end
            S_BUS: begin
                if (hit_err) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    pend_d  = ST_ERR;
                    state_d = S_DONE;
                end else if (hit_rty) begin
`ifdef WBM_TIMEOUT_EN
                    to_d = '0;
`endif
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    if (retry_q < RW'(RETRY_MAX)) begin
                        retry_d = retry_q + RW'(1);
                        state_d = S_BACKOFF;
                    end else begin
                        pend_d  = ST_RTY;
                        state_d = S_DONE;
                    end
                end else if (hit_ack) begin
                    if (!we_q) begin
                        rdat_d = wb.DAT_I;
                        rvld_d = 1'b1;
                    end
                    if (beats_q != '0) begin
                        adr_d   = adr_q + AW'(SW);
                        beats_d = beats_q - LENW'(1);
                        retry_d = '0;
`ifdef WBM_TIMEOUT_EN
                        to_d    = '0;
`endif
                        if (we_q) begin
                            dat_d     = wdat_i;
                            wdat_next = 1'b1;
                        end
                    end else begin
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        pend_d  = ST_OK;
                        state_d = S_DONE;
                    end
                end
`ifdef WBM_TIMEOUT_EN
                else if (to_q == TW'(TIMEOUT - 1)) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    pend_d  = ST_TOUT;
                    state_d = S_DONE;
                end else begin
                    to_d = to_q + TW'(1);
                end
`endif
            end
            S_BACKOFF: begin
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
                state_d = S_BUS;
            end
            S_DONE: begin
                done_d   = 1'b1;
                status_d = pend_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset drops the bus immediately and suppresses done.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q  <= S_IDLE;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            beats_q  <= '0;
            retry_q  <= '0;
            pend_q   <= ST_OK;
            status_q <= ST_OK;
            done_q   <= 1'b0;
            rdat_q   <= '0;
            rvld_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            beats_q  <= beats_d;
            retry_q  <= retry_d;
            pend_q   <= pend_d;
            status_q <= status_d;
            done_q   <= done_d;
            rdat_q   <= rdat_d;
            rvld_q   <= rvld_d;
        end
    end

`ifdef WBM_TIMEOUT_EN
    // Per-beat silence counter.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            to_q <= '0;
        end else begin
            to_q <= to_d;
        end
    end
`endif

    assign wb.ADR_O   = adr_q;
    assign wb.DAT_O   = dat_q;
    assign wb.SEL_O   = sel_q;
    assign wb.CYC_O   = cyc_q;
    assign wb.STB_O   = stb_q;
    assign wb.WE_O    = we_q;
    assign rdat_o     = rdat_q;
    assign rdat_valid = rvld_q;
    assign done       = done_q;
    assign status     = status_q;
endmodule

// File: tb/tb_wb_master_engine.sv
// Directed bench for wb_master_engine: single write, read burst, retries, error abort, silent slave.
// Inputs change 1ns after each rising edge; outputs are read there or on the falling edge.
// Slave responses are driven inline by the stimulus sequence.
`timescale 1ns/1ps
module tb_wb_master_engine;
    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int LENW = 3;

    logic            CLK_I = 1'b0;
    logic            RST_I;
    logic            cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0]   cmd_adr;
    logic [LENW-1:0] cmd_len;
    logic [DW/8-1:0] cmd_sel;
    logic [DW-1:0]   wdat_i;
    logic            wdat_next;
    logic [DW-1:0]   rdat_o;
    logic            rdat_valid, done;
    logic [1:0]      status;

    wb_master_engine_if #(.DW(DW), .AW(AW)) wb ();

    wb_master_engine #(.DW(DW), .AW(AW), .LENW(LENW), .RETRY_MAX(3), .TIMEOUT(255)) dut (
        .CLK_I      (CLK_I),
        .RST_I      (RST_I),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_adr    (cmd_adr),
        .cmd_len    (cmd_len),
        .cmd_sel    (cmd_sel),
        .wdat_i     (wdat_i),
        .wdat_next  (wdat_next),
        .rdat_o     (rdat_o),
        .rdat_valid (rdat_valid),
        .done       (done),
        .status     (status),
        .wb         (wb)
    );

    always #5 CLK_I = ~CLK_I;

    int n_checks = 0;
    int n_pass   = 0;

    // Event counters sampled mid-cycle.
    int   n_wnext = 0, n_done = 0, n_stb = 0, n_cycdrop = 0, n_rv = 0;
    logic stb_prev = 1'b0, cyc_prev = 1'b0;
    always @(negedge CLK_I) begin
        if (wdat_next) n_wnext++;
        if (done) n_done++;
        if (rdat_valid) n_rv++;
        if (wb.STB_O && !stb_prev) n_stb++;
        if (!wb.CYC_O && cyc_prev) n_cycdrop++;
        stb_prev = wb.STB_O;
        cyc_prev = wb.CYC_O;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] adr, input logic [LENW-1:0] len,
                         input logic [DW/8-1:0] sel, input logic [DW-1:0] w0, input logic [DW-1:0] w1);
        int guard = 0;
        while (!cmd_ready && guard < 20) begin
            cyc();
            guard++;
        end
        check("cmd_ready_before_accept", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_len = len; cmd_sel = sel; wdat_i = w0;
        #1;
        check("wdat_next_on_accept", 64'(wdat_next), 64'(we));
        cyc();
        cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = '1; cmd_len = '0; cmd_sel = '0; wdat_i = w1;
        check("bus_after_accept", 64'({wb.CYC_O, wb.STB_O, wb.WE_O}), 64'({1'b1, 1'b1, we}));
    endtask

    // rsp = {ERR, RTY, ACK}; captures the beat's address and write data.
    task automatic respond(input string tag, input logic [2:0] rsp, input int waits,
                           input logic [DW-1:0] rd, output logic [AW-1:0] a, output logic [DW-1:0] d);
        int guard = 0;
        while (!wb.STB_O && guard < 20) begin
            cyc();
            guard++;
        end
        check({tag, "_stb"}, 64'(wb.STB_O), 64'(1));
        a = wb.ADR_O;
        d = wb.DAT_O;
        repeat (waits) cyc();
        check({tag, "_stb_held"}, 64'(wb.STB_O), 64'(1));
        wb.ERR_I = rsp[2]; wb.RTY_I = rsp[1]; wb.ACK_I = rsp[0]; wb.DAT_I = rd;
        cyc();
        wb.ERR_I = 1'b0; wb.RTY_I = 1'b0; wb.ACK_I = 1'b0; wb.DAT_I = '0;
    endtask

    task automatic wait_done(input string tag, input logic [1:0] st, input int budget);
        int guard = 0;
        while (!done && guard < budget) begin
            cyc();
            guard++;
        end
        check({tag, "_done"}, 64'(done), 64'(1));
        check({tag, "_status"}, 64'(status), 64'(st));
        check({tag, "_ready_during_done"}, 64'(cmd_ready), 64'(0));
        cyc();
        check({tag, "_done_ends_ready"}, 64'({done, cmd_ready}), 64'(2'b01));
    endtask

    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int base_w, base_d, base_s, base_c, base_r, cnt;

    initial begin
        RST_I = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_len = '0; cmd_sel = '0; wdat_i = '0;
        wb.ACK_I = 1'b0; wb.ERR_I = 1'b0; wb.RTY_I = 1'b0; wb.DAT_I = '0;
        repeat (3) cyc();

        // Reset state
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_bus", 64'({wb.CYC_O, wb.STB_O, wb.WE_O}), 64'(0));
        check("rst_adr", 64'(wb.ADR_O), 64'(0));
        check("rst_done_rv", 64'({done, rdat_valid}), 64'(0));
        check("rst_status", 64'(status), 64'(0));
        RST_I = 1'b0;
        cyc();

        // Single write, two wait states
        base_w = n_wnext; base_d = n_done;
        issue(1'b1, 32'h10, 3'd0, 4'hF, 32'hA5A5_0001, 32'hDEAD_BEEF);
        respond("wr1", 3'b001, 2, '0, a, d);
        check("wr1_adr", 64'(a), 64'h10);
        check("wr1_dat", 64'(d), 64'hA5A5_0001);
        check("wr1_sel", 64'(wb.SEL_O), 64'hF);
        check("wr1_bus_drop", 64'({wb.CYC_O, wb.STB_O, done}), 64'(0));
        cyc();
        check("wr1_done_n2", 64'({done, status}), 64'(3'b100));
        check("wr1_ready_n2", 64'(cmd_ready), 64'(0));
        cyc();
        check("wr1_ready_n3", 64'({done, cmd_ready}), 64'(2'b01));
        check("wr1_wdat_next_count", 64'(n_wnext - base_w), 64'(1));
        check("wr1_done_count", 64'(n_done - base_d), 64'(1));

        // Read burst of four from 0x100
        base_c = n_cycdrop; base_r = n_rv; base_d = n_done;
        issue(1'b0, 32'h100, 3'd3, 4'h1, '0, '0);
        check("rd_sel_all_ones", 64'(wb.SEL_O), 64'hF);
        for (int i = 0; i < 4; i++) begin
            respond("rd", 3'b001, 0, DW'(i + 1), a, d);
            check("rd_adr", 64'(a), 64'(32'h100 + 4 * i));
            check("rd_rvalid", 64'(rdat_valid), 64'(1));
            check("rd_rdat", 64'(rdat_o), 64'(i + 1));
        end
        wait_done("rd", 2'b00, 10);
        check("rd_rv_count", 64'(n_rv - base_r), 64'(4));
        check("rd_cyc_single_drop", 64'(n_cycdrop - base_c), 64'(1));
        check("rd_done_count", 64'(n_done - base_d), 64'(1));

        // Write beat retried twice, then acknowledged
        base_s = n_stb; base_w = n_wnext;
        issue(1'b1, 32'h20, 3'd0, 4'h3, 32'hDEAD_0003, 32'h1111_1111);
        for (int i = 0; i < 2; i++) begin
            respond("rty", 3'b010, 0, '0, a, d);
            check("rty_adr", 64'(a), 64'h20);
            check("rty_dat", 64'(d), 64'hDEAD_0003);
            check("rty_gap", 64'({wb.CYC_O, wb.STB_O}), 64'(0));
            wb.ACK_I = 1'b1;
            cyc();
            wb.ACK_I = 1'b0;
            check("rty_ack_ignored_in_gap", 64'({wb.STB_O, done}), 64'(2'b10));
        end
        respond("rty_ack", 3'b001, 0, '0, a, d);
        check("rty_final_adr_dat", 64'({a, d}), 64'({32'h20, 32'hDEAD_0003}));
        check("rty_sel", 64'(wb.SEL_O), 64'h3);
        wait_done("rty", 2'b00, 10);
        check("rty_strobes", 64'(n_stb - base_s), 64'(3));
        check("rty_wdat_next_count", 64'(n_wnext - base_w), 64'(1));

        // Retry on every strobe exhausts the budget
        base_s = n_stb;
        issue(1'b0, 32'h40, 3'd0, 4'hF, '0, '0);
        for (int i = 0; i < 4; i++) respond("rtyx", 3'b010, 0, '0, a, d);
        check("rtyx_bus_low", 64'({wb.CYC_O, wb.STB_O}), 64'(0));
        wait_done("rtyx", 2'b10, 10);
        check("rtyx_strobes", 64'(n_stb - base_s), 64'(4));

        // ERR together with ACK on beat 2 of a 4-beat write burst
        base_s = n_stb; base_w = n_wnext;
        issue(1'b1, 32'h200, 3'd3, 4'hF, 32'hB000_0000, 32'hB000_0001);
        respond("err_b1", 3'b001, 0, '0, a, d);
        check("err_b1_adr_dat", 64'({a, d}), 64'({32'h200, 32'hB000_0000}));
        wdat_i = 32'hB000_0002;
        respond("err_b2", 3'b101, 1, '0, a, d);
        check("err_b2_adr_dat", 64'({a, d}), 64'({32'h204, 32'hB000_0001}));
        check("err_bus_low", 64'({wb.CYC_O, wb.STB_O}), 64'(0));
        wait_done("err", 2'b01, 10);
        check("err_strobes", 64'(n_stb - base_s), 64'(1));
        check("err_wdat_next_count", 64'(n_wnext - base_w), 64'(2));

        // Silent slave
        base_d = n_done;
        issue(1'b0, 32'h300, 3'd0, 4'hF, '0, '0);
`ifdef WBM_TIMEOUT_EN
        cnt = 0;
        while (wb.CYC_O && cnt < 400) begin
            cnt++;
            cyc();
        end
        check("tout_cycles", 64'(cnt), 64'(255));
        wait_done("tout", 2'b11, 10);
`else
        repeat (300) cyc();
        check("silent_cyc_held", 64'({wb.CYC_O, wb.STB_O, done}), 64'(3'b110));
        RST_I = 1'b1;
        cyc();
        check("silent_rst_bus_low", 64'({wb.CYC_O, wb.STB_O}), 64'(0));
        check("silent_rst_status", 64'(status), 64'(0));
        RST_I = 1'b0;
        repeat (4) cyc();
        check("silent_no_done", 64'(n_done - base_d), 64'(0));
        check("silent_ready", 64'(cmd_ready), 64'(1));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
